// File: rtl/pkt_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_mux_pkg
// Purpose  : Shared word format, packet type codes and FSM states.
// Revision : 1.0
// ============================================================================
package pkt_mux_pkg;

  localparam int DW = 134;

  localparam logic [1:0] PKT_HEAD = 2'b01;
  localparam logic [1:0] PKT_BODY = 2'b11;
  localparam logic [1:0] PKT_TAIL = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pkt_in_fifo
// Purpose  : Per-channel word FIFO plus per-packet valid-flag FIFO.
// Revision : 1.0
// ============================================================================
module pkt_in_fifo
  import pkt_mux_pkg::*;
#(
  parameter int DATA_DEPTH = 256,
  parameter int PKT_DEPTH  = 16,
  parameter int ALF_MARGIN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  input  logic          vld_in,
  input  logic          vld_wr,
  input  logic          rd_en,
  input  logic          vld_rd,
  output logic [DW-1:0] rd_data,
  output logic          rd_vld,
  output logic          data_empty,
  output logic          vld_empty,
  output logic          alf,
  output logic          ovf
);

  localparam int DAW = clog2(DATA_DEPTH);
  localparam int VAW = clog2(PKT_DEPTH);

  logic [DAW:0]           dwr_q, dwr_d, drd_q, drd_d;
  logic [VAW:0]           vwr_q, vwr_d, vrd_q, vrd_d;
  logic                   ovf_q, ovf_d;
  logic [DW-1:0]          dmem_q [DATA_DEPTH];
  logic [PKT_DEPTH-1:0]   vmem_q;
  logic                   data_full, vld_full;
  logic [DAW:0]           data_free;
  logic [VAW:0]           vld_free;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign data_empty = (dwr_q == drd_q);
  assign data_full  = (dwr_q[DAW] != drd_q[DAW]) && (dwr_q[DAW-1:0] == drd_q[DAW-1:0]);
  assign vld_empty  = (vwr_q == vrd_q);
  assign vld_full   = (vwr_q[VAW] != vrd_q[VAW]) && (vwr_q[VAW-1:0] == vrd_q[VAW-1:0]);

  assign data_free = (DAW+1)'(DATA_DEPTH) - (dwr_q - drd_q);
  assign vld_free  = (VAW+1)'(PKT_DEPTH) - (vwr_q - vrd_q);
  assign alf       = (32'(data_free) < ALF_MARGIN) || (32'(vld_free) < 2);

  assign rd_data = dmem_q[drd_q[DAW-1:0]];
  assign rd_vld  = vmem_q[vrd_q[VAW-1:0]];
  assign ovf     = ovf_q;

  always_comb begin
    dwr_d = dwr_q;
    drd_d = drd_q;
    vwr_d = vwr_q;
    vrd_d = vrd_q;
    ovf_d = 1'b0;
    if (wr_en) begin
      if (data_full) ovf_d = 1'b1;
      else           dwr_d = dwr_q + 1'b1;
    end
    if (vld_wr) begin
      if (vld_full) ovf_d = 1'b1;
      else          vwr_d = vwr_q + 1'b1;
    end
    if (rd_en && !data_empty) drd_d = drd_q + 1'b1;
    if (vld_rd && !vld_empty) vrd_d = vrd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwr_q <= '0;
      drd_q <= '0;
      vwr_q <= '0;
      vrd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dwr_q <= dwr_d;
      drd_q <= drd_d;
      vwr_q <= vwr_d;
      vrd_q <= vrd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !data_full) dmem_q[dwr_q[DAW-1:0]] <= wr_data;
    if (vld_wr && !vld_full) vmem_q[vwr_q[VAW-1:0]] <= vld_in;
  end

endmodule
`default_nettype wire

// File: rtl/pkt_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : pkt_mux_n
// Purpose  : N-channel store-and-forward packet mux with RR/forced arbitration.
// Revision : 1.0
// ============================================================================
module pkt_mux_n
  import pkt_mux_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_DEPTH = 256,
  parameter int PKT_DEPTH  = 16,
  parameter int ALF_MARGIN = 32,
  parameter bit DROP_BAD   = 1'b1,
  localparam int SEL_W     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] in_data,
  input  logic [NUM_CH-1:0]    in_data_wr,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH-1:0]    in_valid_wr,
  output logic [NUM_CH-1:0]    in_alf,
  input  logic                 arb_mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [DW-1:0]        out_data,
  output logic                 out_data_wr,
  output logic                 out_valid,
  output logic                 out_valid_wr,
  input  logic                 out_alf,
  output logic [NUM_CH-1:0]    err_ovf
);

  logic [DW-1:0]     ch_data [NUM_CH];
  logic [NUM_CH-1:0] ch_vld_head, ch_data_empty, ch_vld_empty;
  logic [NUM_CH-1:0] rd_en, vld_rd;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pkt_in_fifo #(
        .DATA_DEPTH (DATA_DEPTH),
        .PKT_DEPTH  (PKT_DEPTH),
        .ALF_MARGIN (ALF_MARGIN)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (in_data[c*DW +: DW]),
        .wr_en      (in_data_wr[c]),
        .vld_in     (in_valid[c]),
        .vld_wr     (in_valid_wr[c]),
        .rd_en      (rd_en[c]),
        .vld_rd     (vld_rd[c]),
        .rd_data    (ch_data[c]),
        .rd_vld     (ch_vld_head[c]),
        .data_empty (ch_data_empty[c]),
        .vld_empty  (ch_vld_empty[c]),
        .alf        (in_alf[c]),
        .ovf        (err_ovf[c])
      );
    end
  endgenerate

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  gnt_q, gnt_d, ptr_q, ptr_d;
  logic              drop_q, drop_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_data_wr_q, out_data_wr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_valid_wr_q, out_valid_wr_d;

  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [SEL_W-1:0]  pick, cand;
  logic [DW-1:0]     cur_word;
  logic              cur_tail;

  assign cur_word = ch_data[gnt_q];
  assign cur_tail = (cur_word[DW-1:DW-2] == PKT_TAIL);

  // A channel only competes once its valid flag (i.e. a whole packet) is stored.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int c = 0; c < NUM_CH; c++)
      elig[c] = !ch_vld_empty[c] && (!arb_mode || (sel == SEL_W'(c)));
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = SEL_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    ptr_d          = ptr_q;
    drop_d         = drop_q;
    out_data_d     = out_data_q;
    out_data_wr_d  = 1'b0;
    out_valid_d    = 1'b0;
    out_valid_wr_d = 1'b0;
    rd_en          = '0;
    vld_rd         = '0;
    case (state_q)
      IDLE: begin
        if (!out_alf && found) begin
          state_d = SEND;
          gnt_d   = pick;
          ptr_d   = pick;
          drop_d  = DROP_BAD && !ch_vld_head[pick];
        end
      end
      SEND: begin
        if (!ch_data_empty[gnt_q]) begin
          rd_en[gnt_q] = 1'b1;
          if (!drop_q) begin
            out_data_d    = cur_word;
            out_data_wr_d = 1'b1;
          end
          if (cur_tail) begin
            vld_rd[gnt_q] = 1'b1;
            state_d       = IDLE;
            if (!drop_q) begin
              out_valid_wr_d = 1'b1;
              out_valid_d    = ch_vld_head[gnt_q];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      ptr_q          <= SEL_W'(NUM_CH - 1);
      drop_q         <= 1'b0;
      out_data_q     <= '0;
      out_data_wr_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      ptr_q          <= ptr_d;
      drop_q         <= drop_d;
      out_data_q     <= out_data_d;
      out_data_wr_q  <= out_data_wr_d;
      out_valid_q    <= out_valid_d;
      out_valid_wr_q <= out_valid_wr_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_data_wr  = out_data_wr_q;
  assign out_valid    = out_valid_q;
  assign out_valid_wr = out_valid_wr_q;

endmodule
`default_nettype wire
